pipe_wb_stage: RTL and testbench
================================

// Module: pipe_wb_stage
// PURPOSE
//  Writeback stage; consumes the s5 fields of the MEM/WB pipeline register and drives the regfile write port.
//  Selects ALU vs load data, aligns and zero-extends sub-word loads, and resolves LL/SC via a link reservation.
//  Runs the halt drain/stop state machine. One registered cycle between s5 inputs and the regfile write.
// PARAMETERS
//  BITS          32                    data word width
//  REG_WORDS     32                    regfile depth
//  ADDR_LEFT     $clog2(REG_WORDS)-1   MSB of register address
//  DRAIN_CYCLES  2                     cycles in DRAIN before HALTED, 1..15
// PORTS
//  clk             in   1            system clock, rising edge
//  rst_            in   1            asynchronous active-low reset
//  alu_out_s5      in   BITS         ALU result; the effective address for atomics
//  d_mem_rdata_s5  in   BITS         raw memory read word
//  sel_mem_s5      in   1            1 = load data is the result
//  rw_s5           in   1            active-low regfile write request
//  waddr_s5        in   ADDR_LEFT+1  destination register
//  byte_en_s5      in   4            active-low lane enables; 4'hF = no lanes
//  atomic_s5       in   1            atomic op (LL when sel_mem_s5, else SC)
//  link_rw_s5      in   1            active-low; qualifies SC
//  halt_s5         in   1            halt instruction retiring
//  reg_wdata       out  BITS         regfile write data
//  reg_waddr       out  ADDR_LEFT+1  regfile write address
//  reg_we_         out  1            active-low regfile write strobe
//  link_valid      out  1            LL reservation held
//  halted          out  1            core stopped
//  retire_cnt      out  32           committed-write count (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async assert, sync release): reg_wdata=0, reg_waddr=0, reg_we_=1, link_valid=0, link_addr=0,
//   halted=0, retire_cnt=0, state=RUN, drain_cnt=0, armed=0. armed goes 1 on the first clk after release.
//   While armed=0 no write is committed: rw_s5 has no reset in MEM/WB and is ignored.
//  Commit condition (sampled on posedge): armed & state==RUN & ~rw_s5 & ~halt_s5 & waddr_s5!=0.
//   Commit -> next cycle reg_we_=0 with data/addr. Otherwise reg_we_=1; reg_wdata/reg_waddr hold.
//  Result mux: SC > load > ALU.
//   Load (sel_mem_s5 & ~atomic_s5, or LL), lanes active-low, lane0 = bits[7:0]:
//    4'b0000 -> word; 4'b1100 -> {16'b0,[15:0]}; 4'b0011 -> {16'b0,[31:16]};
//    single zero lane k -> {24'b0, byte k}. Any other pattern -> full word, no error.
//   SC (atomic_s5 & ~sel_mem_s5 & ~link_rw_s5): result = {31'b0, link_valid & (link_addr==alu_out_s5)}.
//   All other ops -> alu_out_s5.
//  Link reservation (flops link_valid, link_addr[BITS-1:0]):
//   LL committed -> link_valid=1, link_addr=alu_out_s5 (overwrites any older link).
//   SC qualified -> link_valid=0 next cycle, pass or fail; a non-committing SC still clears the link.
//   halt_s5 accepted in RUN -> link_valid=0.
//  Halt FSM (RUN, DRAIN, HALTED):
//   RUN   : armed & halt_s5 -> DRAIN, drain_cnt=DRAIN_CYCLES-1; the halt op itself never writes.
//   DRAIN : all s5 inputs ignored; drain_cnt-- each cycle; at 0 -> HALTED.
//   HALTED: halted=1, reg_we_=1; leaves only on reset.
//   halt_s5 with ~rw_s5 in the same cycle: halt wins, write dropped.
//  Reset mid-DRAIN or mid-write: all state returns to reset values immediately, no partial commit.
// CONFIGURATION
//  WB_RETIRE_CNT_EN defined: retire_cnt += 1 per committed write (reg_we_==0), 32-bit wrap 32'hFFFFFFFF->0, frozen in HALTED.
//  Not defined: retire_cnt tied 32'h0, counter flops absent.
// STRUCTURE
//  pipe_pkg: wb_state_t enum {WB_RUN, WB_DRAIN, WB_HALTED}; LANE_WORD=4'h0, LANE_LO16=4'hC,
//   LANE_HI16=4'h3, LANE_NONE=4'hF constants.
//  Sub-module wb_load_align: combinational lane select/zero-extend (byte_en, rdata -> aligned word).
//  Top holds result mux, link flops, halt FSM, drain counter, output register, optional counter.
// TESTING
//  1 Reset, then ~rw_s5, waddr=5, sel_mem=0, alu=32'h1234_5678 -> next cycle reg_we_=0, waddr=5, wdata=32'h1234_5678.
//  2 First cycle after rst_ release with ~rw_s5 -> reg_we_=1; the same op the cycle after -> write committed.
//  3 Load rdata=32'hAABB_CCDD: byte_en 4'b1101 -> 32'h0000_00CC; 4'b0011 -> 32'h0000_AABB; 4'b0000 -> full word.
//  4 LL addr 32'h100 -> link_valid=1; SC addr 32'h100 -> wdata=1, link_valid=0;
//    repeat SC -> wdata=0; LL 32'h100 then SC 32'h104 -> wdata=0.
//  5 halt_s5 with ~rw_s5, waddr=3 -> no write; DRAIN 2 cycles ignores writes; halted=1 on cycle 3; stays until rst_.
//  6 WB_RETIRE_CNT_EN: 3 writes + 1 to waddr=0 -> retire_cnt=3; preload 32'hFFFF_FFFF, one write -> 0; undefined -> always 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the writeback stage.
//   wb_state_t : halt state machine encoding
//   LANE_*     : active-low byte-lane enable patterns (lane0 = bits[7:0])
package pipe_pkg;

  typedef enum logic [1:0] {
    WB_RUN,
    WB_DRAIN,
    WB_HALTED
  } wb_state_t;

  localparam logic [3:0] LANE_WORD = 4'h0;
  localparam logic [3:0] LANE_LO16 = 4'hC;
  localparam logic [3:0] LANE_HI16 = 4'h3;
  localparam logic [3:0] LANE_NONE = 4'hF;

endpackage

// File: rtl/pipe_wb_stage_if.sv
// MEM/WB s5 fields in, regfile write port out.
//   master : pipeline side (drives s5 fields, observes the write port)
//   slave  : writeback stage (consumes s5 fields, drives the write port)
interface pipe_wb_stage_if #(
  parameter int BITS      = 32,
  parameter int ADDR_LEFT = 4
);
  logic [BITS-1:0]    alu_out_s5;
  logic [BITS-1:0]    d_mem_rdata_s5;
  logic               sel_mem_s5;
  logic               rw_s5;
  logic [ADDR_LEFT:0] waddr_s5;
  logic [3:0]         byte_en_s5;
  logic               atomic_s5;
  logic               link_rw_s5;
  logic               halt_s5;

  logic [BITS-1:0]    reg_wdata;
  logic [ADDR_LEFT:0] reg_waddr;
  logic               reg_we_;

  modport master (
    output alu_out_s5, d_mem_rdata_s5, sel_mem_s5, rw_s5, waddr_s5,
           byte_en_s5, atomic_s5, link_rw_s5, halt_s5,
    input  reg_wdata, reg_waddr, reg_we_
  );

  modport slave (
    input  alu_out_s5, d_mem_rdata_s5, sel_mem_s5, rw_s5, waddr_s5,
           byte_en_s5, atomic_s5, link_rw_s5, halt_s5,
    output reg_wdata, reg_waddr, reg_we_
  );
endinterface

// File: rtl/wb_load_align.sv
// Combinational sub-word load alignment with zero extension.
//   byte_en : active-low lane enables, lane0 = rdata[7:0]
//   rdata   : raw memory read word
//   aligned : selected lanes shifted to bit 0, zero-extended
// Unrecognised lane patterns pass the full word through.
module wb_load_align
  import pipe_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic [3:0]      byte_en,
  input  logic [BITS-1:0] rdata,
  output logic [BITS-1:0] aligned
);

  always_comb begin
    aligned = rdata;
    case (byte_en)
      LANE_WORD: aligned = rdata;
      LANE_LO16: aligned = {{(BITS-16){1'b0}}, rdata[15:0]};
      LANE_HI16: aligned = {{(BITS-16){1'b0}}, rdata[31:16]};
      4'hE:      aligned = {{(BITS-8){1'b0}}, rdata[7:0]};
      4'hD:      aligned = {{(BITS-8){1'b0}}, rdata[15:8]};
      4'hB:      aligned = {{(BITS-8){1'b0}}, rdata[23:16]};
      4'h7:      aligned = {{(BITS-8){1'b0}}, rdata[31:24]};
      LANE_NONE: aligned = rdata;
      default:   aligned = rdata;
    endcase
  end

endmodule

// File: rtl/pipe_wb_stage.sv
// Writeback stage: result select (SC > load > ALU), LL/SC link
// reservation, halt drain/stop FSM and the registered regfile write port.
//   clk, rst_  : clock, asynchronous active-low reset
//   wb         : s5 fields in / regfile write port out (slave modport)
//   link_valid : LL reservation held
//   halted     : core stopped (only reset leaves this)
//   retire_cnt : committed-write count
// Optional feature: define WB_RETIRE_CNT_EN to build the retire counter;
// otherwise retire_cnt is tied to zero.
//
// state     | meaning
// WB_RUN    | normal writeback, commits allowed once armed
// WB_DRAIN  | halt accepted, s5 ignored while drain_cnt runs down
// WB_HALTED | stopped, no writes until reset
module pipe_wb_stage
  import pipe_pkg::*;
#(
  parameter int BITS         = 32,
  parameter int REG_WORDS    = 32,
  parameter int ADDR_LEFT    = $clog2(REG_WORDS) - 1,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_,
  pipe_wb_stage_if.slave wb,
  output logic        link_valid,
  output logic        halted,
  output logic [31:0] retire_cnt
);

  wb_state_t          state;
  logic               armed;
  logic [3:0]         drain_cnt;
  logic [BITS-1:0]    link_addr;
  logic [BITS-1:0]    wdata_q;
  logic [ADDR_LEFT:0] waddr_q;
  logic               we_q_;

  logic [BITS-1:0]    load_data;
  logic [BITS-1:0]    result;
  logic               in_run;
  logic               is_ll;
  logic               is_sc;
  logic               sc_ok;
  logic               commit;

  wb_load_align #(.BITS(BITS)) u_align (
    .byte_en (wb.byte_en_s5),
    .rdata   (wb.d_mem_rdata_s5),
    .aligned (load_data)
  );

  // rw_s5 is not reset in MEM/WB, so nothing is trusted until armed.
  assign in_run = armed & (state == WB_RUN);
  assign is_ll  = wb.atomic_s5 & wb.sel_mem_s5;
  assign is_sc  = wb.atomic_s5 & ~wb.sel_mem_s5 & ~wb.link_rw_s5;
  assign sc_ok  = link_valid & (link_addr == wb.alu_out_s5);
  assign commit = in_run & ~wb.rw_s5 & ~wb.halt_s5 & (wb.waddr_s5 != '0);

  always_comb begin
    result = wb.alu_out_s5;
    if (is_sc)
      result = {{(BITS-1){1'b0}}, sc_ok};
    else if (wb.sel_mem_s5)
      result = load_data;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state      <= WB_RUN;
      armed      <= 1'b0;
      drain_cnt  <= 4'd0;
      halted     <= 1'b0;
      link_valid <= 1'b0;
      link_addr  <= '0;
      wdata_q    <= '0;
      waddr_q    <= '0;
      we_q_      <= 1'b1;
    end else begin
      armed <= 1'b1;
      we_q_ <= ~commit;
      if (commit) begin
        wdata_q <= result;
        waddr_q <= wb.waddr_s5;
      end

      // A qualified SC drops the link whether or not it writes.
      if (in_run & wb.halt_s5)
        link_valid <= 1'b0;
      else if (commit & is_ll) begin
        link_valid <= 1'b1;
        link_addr  <= wb.alu_out_s5;
      end else if (in_run & is_sc)
        link_valid <= 1'b0;

      case (state)
        WB_RUN: begin
          if (armed & wb.halt_s5) begin
            state     <= WB_DRAIN;
            drain_cnt <= 4'(DRAIN_CYCLES - 1);
          end
        end
        WB_DRAIN: begin
          if (drain_cnt == 4'd0) begin
            state  <= WB_HALTED;
            halted <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end
        WB_HALTED: halted <= 1'b1;
        default:   state  <= WB_RUN;
      endcase
    end
  end

  assign wb.reg_wdata = wdata_q;
  assign wb.reg_waddr = waddr_q;
  assign wb.reg_we_   = we_q_;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q;

  // No commits happen outside RUN, so the count freezes once halted.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)
      retire_cnt_q <= 32'h0;
    else if (commit)
      retire_cnt_q <= retire_cnt_q + 32'd1;
  end

  assign retire_cnt = retire_cnt_q;
`else
  assign retire_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_wb_stage.sv
module tb_pipe_wb_stage;

  logic        clk;
  logic        rst_;
  logic        link_valid;
  logic        halted;
  logic [31:0] retire_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pipe_wb_stage_if #(.BITS(32), .ADDR_LEFT(4)) bus ();

  pipe_wb_stage #(
    .BITS         (32),
    .REG_WORDS    (32),
    .DRAIN_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst_       (rst_),
    .wb         (bus.slave),
    .link_valid (link_valid),
    .halted     (halted),
    .retire_cnt (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_out_s5     = 32'h0;
    bus.d_mem_rdata_s5 = 32'h0;
    bus.sel_mem_s5     = 1'b0;
    bus.rw_s5          = 1'b1;
    bus.waddr_s5       = 5'd0;
    bus.byte_en_s5     = 4'h0;
    bus.atomic_s5      = 1'b0;
    bus.link_rw_s5     = 1'b1;
    bus.halt_s5        = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.rw_s5 = 1'b0; bus.waddr_s5 = a; bus.alu_out_s5 = d;
  endtask

  task automatic ld(input logic [3:0] be, input logic [31:0] exp, input string tag);
    bus.byte_en_s5 = be;
    step();
    chk({tag, "_we"}, 32'(bus.reg_we_), 32'h0);
    chk(tag, bus.reg_wdata, exp);
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    idle();
    repeat (2) step();
  endtask

  initial begin
    rst_ = 1'b0;
    idle();
    repeat (2) step();
    chk("rst_we", 32'(bus.reg_we_), 32'h1);
    chk("rst_wdata", bus.reg_wdata, 32'h0);
    chk("rst_waddr", 32'(bus.reg_waddr), 32'h0);
    chk("rst_link", 32'(link_valid), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_retire", retire_cnt, 32'h0);

    // Write request present at release: first edge only arms.
    @(negedge clk);
    rst_ = 1'b1;
    wr(5'd5, 32'h1234_5678);
    step();
    chk("unarmed_we", 32'(bus.reg_we_), 32'h1);
    step();
    chk("wr_we", 32'(bus.reg_we_), 32'h0);
    chk("wr_waddr", 32'(bus.reg_waddr), 32'h5);
    chk("wr_wdata", bus.reg_wdata, 32'h1234_5678);

    wr(5'd0, 32'h5555_5555);
    step();
    chk("r0_we", 32'(bus.reg_we_), 32'h1);
    chk("r0_hold", bus.reg_wdata, 32'h1234_5678);
    bus.rw_s5 = 1'b1; bus.waddr_s5 = 5'd6;
    step();
    chk("norw_we", 32'(bus.reg_we_), 32'h1);

    // Loads.
    wr(5'd9, 32'hFFFF_0000);
    bus.sel_mem_s5 = 1'b1;
    bus.d_mem_rdata_s5 = 32'hAABB_CCDD;
    ld(4'b1101, 32'h0000_00CC, "ld_b1");
    ld(4'b0011, 32'h0000_AABB, "ld_hi16");
    ld(4'b0000, 32'hAABB_CCDD, "ld_word");
    ld(4'b1100, 32'h0000_CCDD, "ld_lo16");
    ld(4'b0111, 32'h0000_00AA, "ld_b3");
    ld(4'b1110, 32'h0000_00DD, "ld_b0");
    ld(4'b0101, 32'hAABB_CCDD, "ld_odd");

    // LL / SC.
    bus.atomic_s5 = 1'b1; bus.byte_en_s5 = 4'h0;
    wr(5'd7, 32'h100);
    step();
    chk("ll_link", 32'(link_valid), 32'h1);
    chk("ll_data", bus.reg_wdata, 32'hAABB_CCDD);
    bus.sel_mem_s5 = 1'b0; bus.link_rw_s5 = 1'b0; bus.waddr_s5 = 5'd8;
    step();
    chk("sc_pass", bus.reg_wdata, 32'h1);
    chk("sc_clr", 32'(link_valid), 32'h0);
    step();
    chk("sc_again", bus.reg_wdata, 32'h0);
    chk("sc_again_we", 32'(bus.reg_we_), 32'h0);
    bus.sel_mem_s5 = 1'b1; bus.alu_out_s5 = 32'h100;
    step();
    bus.sel_mem_s5 = 1'b0; bus.alu_out_s5 = 32'h104;
    step();
    chk("sc_addr_miss", bus.reg_wdata, 32'h0);
    chk("sc_miss_clr", 32'(link_valid), 32'h0);
    bus.sel_mem_s5 = 1'b1; bus.alu_out_s5 = 32'h100;
    step();
    bus.sel_mem_s5 = 1'b0; bus.rw_s5 = 1'b1;
    step();
    chk("sc_nowr_clr", 32'(link_valid), 32'h0);
    chk("sc_nowr_we", 32'(bus.reg_we_), 32'h1);
    bus.rw_s5 = 1'b0;
    step();
    chk("sc_after_clr", bus.reg_wdata, 32'h0);
    bus.sel_mem_s5 = 1'b1;
    step();
    bus.sel_mem_s5 = 1'b0; bus.link_rw_s5 = 1'b1;
    step();
    chk("unq_sc_alu", bus.reg_wdata, 32'h100);
    chk("unq_sc_link", 32'(link_valid), 32'h1);

    // Halt with a write in the same cycle: halt wins.
    bus.atomic_s5 = 1'b0;
    wr(5'd3, 32'hDEAD_0001);
    bus.halt_s5 = 1'b1;
    step();
    chk("halt_nowr", 32'(bus.reg_we_), 32'h1);
    chk("halt_link", 32'(link_valid), 32'h0);
    chk("halt_c1", 32'(halted), 32'h0);
    bus.halt_s5 = 1'b0;
    wr(5'd3, 32'hBEEF_0002);
    step();
    chk("drain_we", 32'(bus.reg_we_), 32'h1);
    chk("halt_c2", 32'(halted), 32'h0);
    step();
    chk("halt_c3", 32'(halted), 32'h1);
    chk("halted_we", 32'(bus.reg_we_), 32'h1);
    repeat (3) step();
    chk("halt_stay", 32'(halted), 32'h1);
    chk("halt_hold", bus.reg_wdata, 32'h100);

    // Retire counter.
    do_reset();
    @(negedge clk);
    rst_ = 1'b1;
    step();
    for (int i = 1; i <= 3; i++) begin
      wr(5'(i), 32'(i));
      step();
    end
    wr(5'd0, 32'h77);
    step();
    bus.rw_s5 = 1'b1;
    step();
`ifdef WB_RETIRE_CNT_EN
    chk("retire_3", retire_cnt, 32'd3);
    dut.retire_cnt_q = 32'hFFFF_FFFF;
    wr(5'd4, 32'h4);
    step();
    chk("retire_wrap", retire_cnt, 32'h0);
`else
    chk("retire_off", retire_cnt, 32'h0);
`endif

    // Reset asserted mid-DRAIN.
    bus.halt_s5 = 1'b1;
    step();
    bus.halt_s5 = 1'b0;
    wr(5'd2, 32'h2222);
    step();
    #2;
    rst_ = 1'b0;
    #1;
    chk("mid_rst_we", 32'(bus.reg_we_), 32'h1);
    chk("mid_rst_wdata", bus.reg_wdata, 32'h0);
    chk("mid_rst_retire", retire_cnt, 32'h0);
    @(negedge clk);
    rst_ = 1'b1;
    step();
    step();
    chk("post_rst_we", 32'(bus.reg_we_), 32'h0);
    chk("post_rst_data", bus.reg_wdata, 32'h2222);
    step();
    step();
    chk("post_rst_run", 32'(halted), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
